// File: rtl/rv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : rv_mem_pkg                                             |
// | Description : Shared types and defaults for the IF/DM memory port    |
// |               arbiter of the RV32I pipeline.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package rv_mem_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4,
    ERR     = 3'd5
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/flopenrc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : flopenrc                                               |
// | Description : Enabled register with async active-low reset and a     |
// |               synchronous clear qualified by the enable.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module flopenrc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d (or zero on clear) whenever enabled; otherwise retain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      if (clear) q <= '0;
      else       q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_req_mux                                            |
// | Description : Selects the memory request fields of the granted       |
// |               requester. Fetches are full-word reads.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_req_mux
  import rv_mem_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  grant_t            grant,
  input  logic [AW-1:0]     if_addr,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  input  logic [DW/8-1:0]   dm_be,
  output logic [AW-1:0]     sel_addr,
  output logic              sel_we,
  output logic [DW-1:0]     sel_wdata,
  output logic [DW/8-1:0]   sel_be
);

  // Fetch fields by default; override with the data port when it is granted.
  always_comb begin
    sel_addr  = if_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_be    = '1;
    if (grant == GNT_DM) begin
      sel_addr  = dm_addr;
      sel_we    = dm_we;
      sel_wdata = dm_wdata;
      // Loads read the whole word; only stores carry real byte enables.
      sel_be    = dm_we ? dm_be : '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                       |
// | Description : Round-robin arbiter sharing one variable-latency       |
// |               memory port between instruction fetch and the data     |
// |               stage, with per-requester stalls and a watchdog.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [DW-1:0]     if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  input  logic [DW/8-1:0]   dm_be,
  output logic [DW-1:0]     dm_rdata,
  output logic              dm_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_rdata,
  output logic              bus_err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic [CW-1:0]         wd_cnt_q, wd_cnt_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]       mem_be_q, mem_be_d;
  logic                  bus_err_q, bus_err_d;

  grant_t                w_grant;
  logic [AW-1:0]         w_sel_addr;
  logic                  w_sel_we;
  logic [DW-1:0]         w_sel_wdata;
  logic [DW/8-1:0]       w_sel_be;
  logic                  w_wd_expire;
  logic                  w_if_cap;
  logic                  w_dm_cap;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_grant = GNT_IF;
    if (dm_req && (!if_req || (last_grant_q == GNT_IF))) w_grant = GNT_DM;
  end

  mem_req_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .grant     (w_grant),
    .if_addr   (if_addr),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .sel_addr  (w_sel_addr),
    .sel_we    (w_sel_we),
    .sel_wdata (w_sel_wdata),
    .sel_be    (w_sel_be)
  );

  // This BUSY cycle without mem_ready would bring the wait count to TIMEOUT.
  assign w_wd_expire = (TIMEOUT != 0) && ((32'(wd_cnt_q) + 32'd1) == 32'(TIMEOUT));

  // Next-state, memory request registers and watchdog.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_valid_d  = 1'b1;
          mem_we_d     = w_sel_we;
          mem_addr_d   = w_sel_addr;
          mem_wdata_d  = w_sel_wdata;
          mem_be_d     = w_sel_be;
          last_grant_d = w_grant;
          wd_cnt_d     = '0;
          state_d      = (w_grant == GNT_DM) ? BUSY_DM : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          // A flushed requester gets no response cycle; its result is dropped.
          if (state_q == BUSY_IF) state_d = if_req ? RESP_IF : IDLE;
          else                    state_d = dm_req ? RESP_DM : IDLE;
        end else if (w_wd_expire) begin
          mem_valid_d = 1'b0;
          bus_err_d   = 1'b1;
          state_d     = ERR;
        end else begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      RESP_IF, RESP_DM: state_d = IDLE;
      ERR:              state_d = ERR;
      default:          state_d = IDLE;
    endcase
  end

  // State and memory request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      wd_cnt_q     <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Capture read data only for a completing access whose requester is still waiting.
  assign w_if_cap = (state_q == BUSY_IF) && mem_ready && if_req;
  assign w_dm_cap = (state_q == BUSY_DM) && mem_ready && dm_req;

  flopenrc #(.WIDTH(DW)) u_if_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_if_cap),
    .clear   (1'b0),
    .d       (mem_rdata),
    .q       (if_rdata)
  );

  flopenrc #(.WIDTH(DW)) u_dm_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_dm_cap),
    .clear   (1'b0),
    .d       (mem_rdata),
    .q       (dm_rdata)
  );

  assign if_stall  = if_req && (state_q != RESP_IF);
  assign dm_stall  = dm_req && (state_q != RESP_DM);
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                    |
// | Description : Self-checking bench for mem_port_arbiter.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [31:0]   if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]    dm_be;
  logic [31:0]   if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic          if_stall, dm_stall, mem_valid, mem_we, bus_err;
  logic [3:0]    mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_stall  (dm_stall),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_be = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        rdy;
    logic [31:0] rdata;
    logic        x_if_stall;
    logic        x_dm_stall;
    logic        x_mv;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_be;
    logic        c_ird;
    logic [31:0] x_ird;
  } vec_t;

  function automatic vec_t mkv(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                               logic [31:0] dwd, logic [3:0] db, logic rdy, logic [31:0] rd,
                               logic xis, logic xds, logic xmv, logic xwe, logic [31:0] xa,
                               logic [31:0] xwd, logic [3:0] xbe, logic cir, logic [31:0] xir);
    vec_t v;
    v = '{ir, ia, dr, dw, da, dwd, db, rdy, rd, xis, xds, xmv, xwe, xa, xwd, xbe, cir, xir};
    return v;
  endfunction

  vec_t vt [11];

  // ---------------- random reference model state ----------------
  logic [31:0] mem_model [16];
  bit  if_busy, dm_busy, if_resp_now, dm_resp_now, if_resp_next, dm_resp_next;
  bit  acc_active, prev_mv, prev_if_req, prev_dm_req, prev_resp;
  bit  issue, exp_issue;
  int  wait_left, last_g, cur_g, rr_k;
  logic [31:0] exp_if_rd, exp_dm_rd, held_addr;
  logic [31:0] rr_exp [4];
  bit  if_bump, dm_bump;

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #3;
    // Reset state, observed while reset is held.
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_be",    mem_be, 0);
    chk("rst_bus_err",   bus_err, 0);
    chk("rst_if_rdata",  if_rdata, 0);
    chk("rst_dm_rdata",  dm_rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single fetch, then a 3-wait-state store; junk mem_ready in RESP/IDLE.
    vt[0]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h00500093,        1, 0, 1, 0, 32'h100, 0, 4'hF, 0, 0);
    vt[2]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h0,               0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
    vt[3]  = mkv(0, 0,       0, 0, 0, 0, 0, 1, 32'h0,               0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mkv(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mkv(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0,    0, 1, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0);
    vt[6]  = mkv(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0,    0, 1, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0);
    vt[7]  = mkv(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0,    0, 1, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0);
    vt[8]  = mkv(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 1, 32'h0BADF00D, 0, 1, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0);
    vt[9]  = mkv(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
    vt[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);

    for (int i = 0; i < 11; i++) begin
      if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      dm_req = vt[i].dm_req; dm_we = vt[i].dm_we; dm_addr = vt[i].dm_addr;
      dm_wdata = vt[i].dm_wdata; dm_be = vt[i].dm_be;
      mem_ready = vt[i].rdy; mem_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_if_stall", i), if_stall, vt[i].x_if_stall);
      chk($sformatf("vec%0d_dm_stall", i), dm_stall, vt[i].x_dm_stall);
      chk($sformatf("vec%0d_mem_valid", i), mem_valid, vt[i].x_mv);
      if (vt[i].x_mv) begin
        chk($sformatf("vec%0d_mem_we", i), mem_we, vt[i].x_we);
        chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].x_addr);
        chk($sformatf("vec%0d_mem_be", i), mem_be, vt[i].x_be);
        if (vt[i].x_we) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].x_wdata);
      end
      if (vt[i].c_ird) chk($sformatf("vec%0d_if_rdata", i), if_rdata, vt[i].x_ird);
      next_cycle();
    end

    // Both requesters continuously busy from reset: DM, IF, DM, IF.
    do_reset();
    rr_exp[0] = 32'h80; rr_exp[1] = 32'h40; rr_exp[2] = 32'h84; rr_exp[3] = 32'h44;
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    rr_k = 0; prev_mv = 0; if_bump = 0; dm_bump = 0;
    for (int c = 0; c < 40 && rr_k < 4; c++) begin
      if (if_bump) if_addr = if_addr + 4;
      if (dm_bump) dm_addr = dm_addr + 4;
      if_bump = 0; dm_bump = 0;
      mem_ready = mem_valid; mem_rdata = 32'h0;
      @(negedge clk);
      if (mem_valid && !prev_mv) begin
        chk($sformatf("rr_grant%0d_addr", rr_k), mem_addr, rr_exp[rr_k]);
        rr_k++;
      end
      if (if_req && !if_stall) if_bump = 1;
      if (dm_req && !dm_stall) dm_bump = 1;
      prev_mv = mem_valid;
      next_cycle();
    end
    chk("rr_grant_count", rr_k, 4);

    // Flush while BUSY_DM: result discarded, arbiter returns straight to IDLE.
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    @(negedge clk); next_cycle();
    mem_ready = 1; mem_rdata = 32'h11112222;
    @(negedge clk); chk("fl_load_valid", mem_valid, 1); next_cycle();
    mem_ready = 0;
    @(negedge clk);
    chk("fl_load_release", dm_stall, 0);
    chk("fl_load_rdata", dm_rdata, 32'h11112222);
    next_cycle();
    dm_addr = 32'h304;
    @(negedge clk); next_cycle();
    dm_req = 0;
    @(negedge clk);
    chk("fl_busy_valid", mem_valid, 1);
    chk("fl_dropped_stall", dm_stall, 0);
    next_cycle();
    @(negedge clk); chk("fl_addr_held", mem_addr, 32'h304); next_cycle();
    mem_ready = 1; mem_rdata = 32'h99999999;
    @(negedge clk); chk("fl_ready_valid", mem_valid, 1); next_cycle();
    mem_ready = 0; if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    chk("fl_after_valid", mem_valid, 0);
    chk("fl_rdata_kept", dm_rdata, 32'h11112222);
    next_cycle();
    mem_ready = 1; mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    chk("fl_idle_issue", mem_valid, 1);
    chk("fl_idle_addr", mem_addr, 32'h500);
    next_cycle();
    mem_ready = 0;
    @(negedge clk);
    chk("fl_fetch_release", if_stall, 0);
    chk("fl_fetch_rdata", if_rdata, 32'hCAFE0001);
    chk("fl_rdata_still", dm_rdata, 32'h11112222);
    next_cycle();

    // Watchdog: 8 BUSY cycles without mem_ready end in ERR.
    do_reset();
    if_req = 1; if_addr = 32'h600;
    @(negedge clk); chk("wd_idle_stall", if_stall, 1); next_cycle();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("wd_busy%0d_valid", i), mem_valid, 1);
      chk($sformatf("wd_busy%0d_err", i), bus_err, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("wd_err_set", bus_err, 1);
    chk("wd_err_valid", mem_valid, 0);
    chk("wd_err_if_stall", if_stall, 1);
    next_cycle();
    dm_req = 1; mem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wd_err_dm_stall", dm_stall, 1);
      chk("wd_err_if_hold", if_stall, 1);
      chk("wd_err_sticky", bus_err, 1);
      chk("wd_err_novalid", mem_valid, 0);
      next_cycle();
    end

    // Async reset clears bus_err and aborts BUSY_IF without a clock edge.
    #2 reset_n = 1'b0;
    #1 chk("ar_err_clear", bus_err, 0);
    idle_inputs();
    next_cycle();
    reset_n = 1'b1;
    if_req = 1; if_addr = 32'h700;
    next_cycle();
    chk("ar_busy_valid", mem_valid, 1);
    #1 reset_n = 1'b0;
    #1 chk("ar_valid_drop", mem_valid, 0);
    chk("ar_err_zero", bus_err, 0);
    next_cycle();
    reset_n = 1'b1; if_addr = 32'h704;
    @(negedge clk); chk("ar_fresh_stall", if_stall, 1); next_cycle();
    mem_ready = 1; mem_rdata = 32'h13579BDF;
    @(negedge clk);
    chk("ar_fresh_valid", mem_valid, 1);
    chk("ar_fresh_addr", mem_addr, 32'h704);
    next_cycle();
    mem_ready = 0;
    @(negedge clk);
    chk("ar_fresh_release", if_stall, 0);
    chk("ar_fresh_rdata", if_rdata, 32'h13579BDF);
    next_cycle();

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    if_busy = 0; dm_busy = 0; if_resp_next = 0; dm_resp_next = 0; acc_active = 0;
    prev_mv = 0; prev_if_req = 0; prev_dm_req = 0; prev_resp = 0;
    last_g = 0; cur_g = 0; wait_left = 0; held_addr = 0; exp_if_rd = 0; exp_dm_rd = 0;
    for (int c = 0; c < 600; c++) begin
      if (!if_busy) begin
        if ($urandom_range(0, 1) == 1) begin
          if_req = 1; if_addr = 32'h1000 + 4 * $urandom_range(0, 15); if_busy = 1;
        end else if_req = 0;
      end
      if (!dm_busy) begin
        if ($urandom_range(0, 1) == 1) begin
          dm_req = 1; dm_addr = 32'h1000 + 4 * $urandom_range(0, 15);
          dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
          dm_be = 4'($urandom_range(1, 15)); dm_busy = 1;
        end else dm_req = 0;
      end
      mem_ready = 0; mem_rdata = $urandom;
      if (mem_valid) begin
        if (!acc_active) begin acc_active = 1; wait_left = $urandom_range(0, 3); end
        if (wait_left == 0) begin
          mem_ready = 1;
          if (!mem_we) mem_rdata = mem_model[mem_addr[5:2]];
          acc_active = 0;
        end else wait_left--;
      end else mem_ready = 1'($urandom_range(0, 1));

      @(negedge clk);
      if_resp_now = if_resp_next; dm_resp_now = dm_resp_next;
      if_resp_next = 0; dm_resp_next = 0;
      chk("rnd_if_stall", if_stall, if_req && !if_resp_now);
      chk("rnd_dm_stall", dm_stall, dm_req && !dm_resp_now);
      issue     = mem_valid && !prev_mv;
      exp_issue = !prev_mv && !prev_resp && (prev_if_req || prev_dm_req);
      chk("rnd_issue", issue, exp_issue);
      if (issue && exp_issue) begin
        if (prev_if_req && prev_dm_req) cur_g = (last_g == 1) ? 0 : 1;
        else                            cur_g = prev_dm_req ? 1 : 0;
        last_g = cur_g;
        held_addr = (cur_g == 1) ? dm_addr : if_addr;
        chk("rnd_issue_addr", mem_addr, held_addr);
        chk("rnd_issue_we", mem_we, (cur_g == 1) && dm_we);
        chk("rnd_issue_be", mem_be, ((cur_g == 1) && dm_we) ? dm_be : 4'hF);
        if ((cur_g == 1) && dm_we) chk("rnd_issue_wdata", mem_wdata, dm_wdata);
      end else if (mem_valid && prev_mv) begin
        chk("rnd_addr_hold", mem_addr, held_addr);
      end
      if (if_resp_now) begin chk("rnd_if_rdata", if_rdata, exp_if_rd); if_busy = 0; end
      if (dm_resp_now) begin
        if (!dm_we) chk("rnd_dm_rdata", dm_rdata, exp_dm_rd);
        dm_busy = 0;
      end
      if (mem_valid && mem_ready) begin
        if (cur_g == 0) begin
          exp_if_rd = mem_model[if_addr[5:2]]; if_resp_next = 1;
        end else begin
          if (dm_we) begin
            for (int b = 0; b < 4; b++)
              if (dm_be[b]) mem_model[dm_addr[5:2]][8*b +: 8] = dm_wdata[8*b +: 8];
          end else exp_dm_rd = mem_model[dm_addr[5:2]];
          dm_resp_next = 1;
        end
      end
      prev_mv = mem_valid; prev_if_req = if_req; prev_dm_req = dm_req;
      prev_resp = if_resp_now || dm_resp_now;
      next_cycle();
    end
    chk("rnd_no_bus_err", bus_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between instruction fetch (IF, read-only) and the data stage (DM, load/store) of the RV32I pipeline.
- Sequences each access with a registered valid/ready handshake toward memory.
- Produces per-requester stall signals that the hazard unit routes to the pipeline register enables and clears.
- Holds read data stable for the release cycle.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables = DW/8)
- TIMEOUT, 64, max BUSY cycles waiting for mem_ready before error; 0 disables the watchdog

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_stall=0
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction, valid when if_req=1 and if_stall=0
- if_stall  out  1  fetch not yet complete
- dm_req  in  1  data request, held until dm_stall=0
- dm_we  in  1  1=store, 0=load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_be  in  DW/8  store byte enables
- dm_rdata  out  DW  load data, valid when dm_req=1 and dm_stall=0
- dm_stall  out  1  data access not yet complete
- mem_valid  out  1  access request to memory (registered)
- mem_we  out  1  write strobe (registered)
- mem_addr  out  AW  (registered)
- mem_wdata  out  DW  (registered)
- mem_be  out  DW/8  (registered); all ones for fetch and loads
- mem_ready  in  1  memory completes the access in this cycle
- mem_rdata  in  DW  read data, valid with mem_ready
- bus_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, all mem_* outputs 0, if_rdata/dm_rdata 0, bus_err 0, last_grant=IF, timeout counter 0.
  - Reset asserted mid-transaction aborts it immediately: mem_valid drops asynchronously and the in-flight result is lost.
- States: IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM, ERR.
- IDLE:
  - If exactly one request is present, grant it.
  - If both are present, grant DM unless last_grant=DM, in which case grant IF (round-robin, so neither requester starves).
  - At the clock edge, load the mem_* registers from the granted requester, set mem_valid=1, set last_grant, and go to BUSY_x.
- BUSY_x:
  - mem_valid and all mem_* outputs stay constant until mem_ready.
  - On mem_ready: capture mem_rdata into the x hold register, drop mem_valid, and go to RESP_x.
  - Stores also pass through RESP_DM; dm_rdata is don't-care for stores.
  - If x_req has dropped (pipeline flush) when mem_ready arrives, the access still completes on the memory side, the result is discarded, and the next state is IDLE, not RESP.
- RESP_x:
  - x_stall=0 for exactly this cycle; x_rdata is driven from the hold register.
  - Next state is IDLE. The other requester's new grant is issued from IDLE on the following cycle, with no back-to-back issue.
- Stall outputs (combinational from state and req):
  - if_stall = if_req and not RESP_IF
  - dm_stall = dm_req and not RESP_DM
  - If x_req=0, x_stall=0.
- Minimum latency: request cycle 0, mem_valid in cycle 1, and with mem_ready in cycle 1 the stall releases in cycle 2. Each further wait state adds one cycle.
- Hold registers retain their value outside RESP; if_rdata and dm_rdata are stable while stalled.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT: go to ERR, drop mem_valid, set bus_err=1.
- ERR: absorbing until reset. Both stalls follow their req, i.e. the pipeline freezes.
- mem_ready outside BUSY is ignored.
- Address and data are not checked for alignment; that is upstream's job.

Decomposition:
- Shared package rv_mem_pkg:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM, ERR)
  - grant_t enum (GNT_IF, GNT_DM)
  - default AW/DW constants
- One natural sub-module, mem_req_mux: a combinational selector of addr/we/wdata/be by grant_t, feeding the mem_* registers.
- Hold registers use the existing flopenrc utility, with en = mem_ready in BUSY_x.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready in the first BUSY cycle, mem_rdata=0x00500093 -> mem_valid in cycle 1 with mem_addr=0x100, if_stall=1 in cycles 0–1, if_stall=0 and if_rdata=0x00500093 in cycle 2.
- Store with 3 wait states: dm_req=1, dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_be=0xF -> mem_* held constant for 4 cycles, dm_stall releases exactly one cycle after mem_ready.
- Simultaneous requests from reset (last_grant=IF): DM granted first, then IF. Re-asserting both afterwards -> IF granted next (round-robin alternation verified across 4 transactions).
- Flush mid-access: dm_req dropped while in BUSY_DM, mem_ready 2 cycles later -> no RESP_DM, state returns to IDLE, dm_rdata unchanged from its previous value.
- Watchdog: TIMEOUT=8, mem_ready held at 0 -> bus_err=1 after 8 BUSY cycles, mem_valid=0, if_stall stays 1 while if_req=1.
- Async reset during BUSY_IF -> mem_valid=0 and bus_err=0 immediately, without waiting for a clock edge; after release, a fresh fetch completes normally.
